// File: rtl/rob_pkg.sv
// Shared types and default sizing for the multi-port reorder buffer.
package rob_pkg;

  localparam int DEF_DEPTH     = 32;
  localparam int DEF_ENQ_W     = 2;
  localparam int DEF_CMT_W     = 2;
  localparam int DEF_WB_PORTS  = 3;
  localparam int DEF_ADDR_BITS = 64;
  localparam int ARCH_REG_W    = 5;
  localparam int PHYS_REG_W    = 7;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    EXC  = 2'd3
  } rob_status_e;

  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0] pc;
    logic [ARCH_REG_W-1:0]    arch_dst;
    logic [PHYS_REG_W-1:0]    phys_dst;
    logic                     is_store;
  } rob_slot_t;

endpackage

// File: rtl/rob_commit_select.sv
// Picks the contiguous run of DONE entries starting at head (up to CMT_W)
// and flags an excepting entry sitting at head.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int CMT_W = DEF_CMT_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  rob_status_e      status [DEPTH],
  input  logic [IDX_W-1:0] head_idx,
  output logic [CMT_W-1:0] commit_mask,
  output logic             exc_at_head
);

  logic             stop;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    commit_mask = '0;
    stop        = 1'b0;
    idx         = head_idx;
    for (int i = 0; i < CMT_W; i++) begin
      idx = head_idx + IDX_W'(i);
      if (!stop && status[idx] == DONE) commit_mask[i] = 1'b1;
      else                              stop           = 1'b1;
    end
  end

  assign exc_at_head = (status[head_idx] == EXC);

endmodule

// File: rtl/multi_port_rob.sv
// Multi-lane reorder buffer: in-order retire of up to CMT_W entries per cycle.
// Define ROB_PARTIAL_FLUSH_EN to make squash keep the branch and older entries.
module multi_port_rob
  import rob_pkg::*;
#(
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int ENQ_W     = DEF_ENQ_W,
  parameter  int CMT_W     = DEF_CMT_W,
  parameter  int WB_PORTS  = DEF_WB_PORTS,
  parameter  int ADDR_BITS = DEF_ADDR_BITS,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                            clk_in,
  input  logic                            rst_N_in,
  input  logic [ENQ_W-1:0]                enq_valid_in,
  input  rob_slot_t [ENQ_W-1:0]           enq_slot_in,
  output logic                            enq_ready_out,
  output logic [ENQ_W-1:0][IDX_W-1:0]     enq_idx_out,
  input  logic [WB_PORTS-1:0]             wb_valid_in,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]  wb_idx_in,
  input  logic [WB_PORTS-1:0]             wb_exc_in,
  input  logic                            squash_valid_in,
  input  logic [IDX_W-1:0]                squash_idx_in,
  output logic [CMT_W-1:0]                commit_valid_out,
  output rob_slot_t [CMT_W-1:0]           commit_slot_out,
  output logic                            flush_out,
  output logic [ADDR_BITS-1:0]            redirect_pc_out,
  output logic [IDX_W:0]                  count_out,
  output logic                            full_out,
  output logic                            empty_out
);

  typedef logic [IDX_W:0] ptr_t;

  rob_status_e      status   [DEPTH];
  rob_status_e      status_n [DEPTH];
  rob_slot_t        slots    [DEPTH];
  ptr_t             head, tail, head_n, tail_n;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic [CMT_W-1:0] sel_mask, commit_mask;
  logic             exc_at_head;
  logic             enq_fire;

  assign head_idx      = head[IDX_W-1:0];
  assign tail_idx      = tail[IDX_W-1:0];
  assign count_out     = tail - head;
  assign empty_out     = (head == tail);
  assign full_out      = (count_out == ptr_t'(DEPTH));
  assign enq_ready_out = ((ptr_t'(DEPTH) - count_out) >= ptr_t'(ENQ_W));
  assign enq_fire      = enq_ready_out && !exc_at_head && !squash_valid_in;

  always_comb begin
    enq_idx_out = '0;
    for (int l = 0; l < ENQ_W; l++) enq_idx_out[l] = tail_idx + IDX_W'(l);
  end

  rob_commit_select #(.DEPTH(DEPTH), .CMT_W(CMT_W)) u_commit_select (
    .status      (status),
    .head_idx    (head_idx),
    .commit_mask (sel_mask),
    .exc_at_head (exc_at_head)
  );

`ifdef ROB_PARTIAL_FLUSH_EN
  logic [IDX_W-1:0] squash_off;
  logic [IDX_W-1:0] age;
  assign squash_off = squash_idx_in - head_idx;

  // Entries younger than the mispredicting branch must not retire alongside the squash.
  always_comb begin
    commit_mask = sel_mask;
    if (squash_valid_in) begin
      for (int i = 0; i < CMT_W; i++)
        if (IDX_W'(i) > squash_off) commit_mask[i] = 1'b0;
    end
  end
`else
  logic unused_squash_idx;
  assign unused_squash_idx = ^squash_idx_in;
  assign commit_mask       = sel_mask;
`endif

  always_comb begin
    status_n = status;
    head_n   = head;
    tail_n   = tail;
`ifdef ROB_PARTIAL_FLUSH_EN
    age      = '0;
`endif
    if (exc_at_head) begin
      for (int i = 0; i < DEPTH; i++) status_n[i] = FREE;
      head_n = '0;
      tail_n = '0;
    end else begin
      for (int i = 0; i < CMT_W; i++) begin
        if (commit_mask[i]) begin
          status_n[head_idx + IDX_W'(i)] = FREE;
          head_n = head_n + ptr_t'(1);
        end
      end
      // Two ports hitting one BUSY slot merge: any exception wins.
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_in[p] && status[wb_idx_in[p]] == BUSY)
          status_n[wb_idx_in[p]] = (wb_exc_in[p] || status_n[wb_idx_in[p]] == EXC) ? EXC : DONE;
      end
      if (squash_valid_in) begin
`ifdef ROB_PARTIAL_FLUSH_EN
        for (int i = 0; i < DEPTH; i++) begin
          age = IDX_W'(i) - head_idx;
          if (age > squash_off) status_n[i] = FREE;
        end
        tail_n = head + ptr_t'(squash_off) + ptr_t'(1);
`else
        for (int i = 0; i < DEPTH; i++) status_n[i] = FREE;
        head_n = '0;
        tail_n = '0;
`endif
      end else if (enq_fire) begin
        for (int l = 0; l < ENQ_W; l++) begin
          if (enq_valid_in[l]) begin
            status_n[tail_idx + IDX_W'(l)] = BUSY;
            tail_n = tail_n + ptr_t'(1);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < DEPTH; i++) status[i] <= FREE;
      head             <= '0;
      tail             <= '0;
      commit_valid_out <= '0;
      commit_slot_out  <= '0;
      flush_out        <= 1'b0;
      redirect_pc_out  <= '0;
    end else begin
      status           <= status_n;
      head             <= head_n;
      tail             <= tail_n;
      commit_valid_out <= commit_mask;
      for (int i = 0; i < CMT_W; i++)
        commit_slot_out[i] <= commit_mask[i] ? slots[head_idx + IDX_W'(i)] : '0;
      flush_out <= exc_at_head;
      if (exc_at_head) redirect_pc_out <= ADDR_BITS'(slots[head_idx].pc);
    end
  end

  // NOTE: the payload array is not reset; a slot is only read once its status shows it was written.
  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      for (int l = 0; l < ENQ_W; l++)
        if (enq_valid_in[l]) slots[tail_idx + IDX_W'(l)] <= enq_slot_in[l];
    end
  end

endmodule

// File: doc/multi_port_rob.md
MULTI_PORT_ROB -- requirements
Module: multi_port_rob

Interface
REQ-001 Parameter: DEPTH, 32, ROB entry count; power of two, at least 4.
REQ-002 Parameter: ENQ_W, 2, dispatch lanes per cycle.
REQ-003 Parameter: CMT_W, 2, maximum in-order commits per cycle.
REQ-004 Parameter: WB_PORTS, 3, completion ports (ALU, LSU, BRU).
REQ-005 Parameter: ADDR_BITS, 64, PC width; IDX_W = $clog2(DEPTH).
REQ-006 Port: clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port: rst_N_in  input  1  reset, asynchronous and active-low.
REQ-008 Port: enq_valid_in  input  ENQ_W  per-lane enqueue request; set lanes are contiguous from lane 0.
REQ-009 Port: enq_slot_in  input  ENQ_W x rob_slot_t  enqueued payload (pc, arch_dst, phys_dst, is_store).
REQ-010 Port: enq_ready_out  output  1  high when free slots >= ENQ_W.
REQ-011 Port: enq_idx_out  output  ENQ_W x IDX_W  index assigned to each lane (tail+lane).
REQ-012 Port: wb_valid_in / wb_idx_in / wb_exc_in  input  WB_PORTS / WB_PORTS x IDX_W / WB_PORTS  completion, target index, exception flag.
REQ-013 Port: squash_valid_in / squash_idx_in  input  1 / IDX_W  branch mispredict; squash_idx_in is the index of the mispredicting branch.
REQ-014 Port: commit_valid_out / commit_slot_out  output  CMT_W / CMT_W x rob_slot_t  retired entries, oldest in lane 0, contiguous.
REQ-015 Port: flush_out / redirect_pc_out  output  1 / ADDR_BITS  exception flush pulse and faulting PC.
REQ-016 Port: count_out / full_out / empty_out  output  IDX_W+1 / 1 / 1  occupancy and status.

Function
REQ-017 Storage: circular buffer; head and tail are IDX_W+1 bits with a wrap bit; full is (ptr diff == DEPTH); empty is (head == tail); wrap across DEPTH-1 -> 0 is transparent.
REQ-018 Entry status: per-slot FREE -> BUSY on enqueue; BUSY -> DONE or EXC on writeback; -> FREE on commit, squash or flush.
REQ-019 Enqueue: when enq_ready_out=1, lanes with enq_valid_in set are written at tail+lane and tail advances by popcount; requests while enq_ready_out=0 are dropped.
REQ-020 enq_ready_out is computed from the registered count only; slots freed by a commit become usable the following cycle.
REQ-021 Writeback: a valid port marks a BUSY slot DONE, or EXC if wb_exc_in=1; writeback to a FREE/DONE/EXC slot is ignored; two ports hitting the same index OR their exc flags.
REQ-022 Commit: scan from head up to CMT_W entries; commit consecutive DONE entries; stop at the first BUSY, FREE or EXC entry.
REQ-023 Commit outputs are registered: one cycle from DONE visible at head to commit_valid_out; unused lanes are zero.
REQ-024 Exception: an EXC entry at head (scan position 0) commits nothing; next edge asserts flush_out for exactly one cycle with redirect_pc_out = that entry's pc; all slots go FREE and head=tail=0.
REQ-025 EXC behind DONE entries: the DONE entries commit this cycle; the flush occurs on a later cycle once the EXC entry reaches head.
REQ-026 During the flush cycle, enqueue, writeback and squash inputs are ignored.
REQ-027 Priority: exception flush > squash > writeback > enqueue; commit and enqueue in the same cycle are both honoured.

Reset
REQ-028 While rst_N_in=0: head=tail=0, all slots FREE, and commit_valid_out, commit_slot_out, flush_out, redirect_pc_out and count_out are 0; empty_out=1, full_out=0, enq_ready_out=1.
REQ-029 Reset asserted mid-operation discards all entries immediately; the first edge after deassertion accepts enqueues.

Configuration
REQ-030 Macro ROB_PARTIAL_FLUSH_EN defined: squash frees all entries younger than squash_idx_in; tail <= squash_idx_in+1 (with wrap bit preserved); older entries and the branch are retained; same-cycle enqueue is dropped.
REQ-031 Macro ROB_PARTIAL_FLUSH_EN undefined: squash_valid_in behaves as a full flush (all slots FREE, head=tail=0, flush_out not asserted); squash_idx_in is unused.

Structure
REQ-032 rob_slot_t, rob_status_e (FREE, BUSY, DONE, EXC) and default parameter constants reside in rob_pkg.
REQ-033 One sub-module, rob_commit_select, computes the combinational commit-lane mask and EXC-at-head detection from the status vector and head.

Verification
REQ-034 Reset, then enqueue 2 per cycle for 16 cycles (DEPTH=32) -> full_out=1, enq_ready_out=0, count_out=32; a 17th enqueue is dropped.
REQ-035 Enqueue idx 0..3; writeback 1,0,3 -> next cycle commit 0,1; idx 3 waits; writeback 2 -> commit 2,3.
REQ-036 Enqueue idx 0..2; writeback 0 DONE, 1 EXC (pc 0x4000) -> commit idx 0; next cycle flush_out=1 for one cycle, redirect_pc_out=0x4000, empty_out=1.
REQ-037 Run head/tail across 31 -> 0 with continuous enqueue and commit for 100 cycles -> commits occur in enqueue order, count_out stays consistent.
REQ-038 With ROB_PARTIAL_FLUSH_EN: entries 0..9, squash_idx_in=4 -> count_out=5, next enq_idx_out=5; without the macro: count_out=0.
REQ-039 Assert rst_N_in low mid-burst for half a cycle -> outputs clear asynchronously and match REQ-028.
